// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-locked arbiter sharing one DLLP transmit AXI-stream among several DLLP sources.
// Port 0 (ACK/NAK) has bounded priority; the other ports are served round-robin.
module pcie_dllp_tx_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_WIDTH    = 3,
  parameter int NUM_REQ       = 4,
  parameter int P0_MAX_CONSEC = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [NUM_REQ*KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic [NUM_REQ-1:0]               s_axis_tvalid,
  input  logic [NUM_REQ-1:0]               s_axis_tlast,
  input  logic [NUM_REQ*USER_WIDTH-1:0]    s_axis_tuser,
  output logic [NUM_REQ-1:0]               s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  output logic [USER_WIDTH-1:0]            m_axis_tuser,
  input  logic                             m_axis_tready,
  input  logic                             enable_i,
  output logic [NUM_REQ-1:0]               grant_o,
  output logic                             busy_o,
  output logic [15:0]                      dllp_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(P0_MAX_CONSEC + 1);
  localparam logic [CNT_W-1:0] CONSEC_MAX = CNT_W'(P0_MAX_CONSEC);
  localparam logic [IDX_W-1:0] FIRST_RR   = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     consec_q, consec_d;
  logic [15:0]          count_q, count_d;

  logic [DATA_WIDTH-1:0] tdata_arr [NUM_REQ];
  logic [KEEP_WIDTH-1:0] tkeep_arr [NUM_REQ];
  logic [USER_WIDTH-1:0] tuser_arr [NUM_REQ];

  logic                 active_s;
  logic                 any_other_s;
  logic                 rr_found_s;
  logic [IDX_W-1:0]     rr_win_s;
  logic                 hs_last_s;

  assign active_s    = (state_q == ST_ACTIVE);
  assign any_other_s = |s_axis_tvalid[NUM_REQ-1:1];
  assign hs_last_s   = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Unpack the flat per-port buses into arrays indexed by port
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      tdata_arr[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      tkeep_arr[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
      tuser_arr[i] = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
    end
  end

  // Round-robin search over ports 1..NUM_REQ-1 starting at rr_ptr
  always_comb begin : rr_search
    int   cand;
    logic hit;
    rr_found_s = 1'b0;
    rr_win_s   = FIRST_RR;
    cand       = 0;
    hit        = 1'b0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand       = ((int'(rr_ptr_q) - 1 + k) % (NUM_REQ - 1)) + 1;
      hit        = s_axis_tvalid[cand] & ~rr_found_s;
      rr_win_s   = hit ? IDX_W'(cand) : rr_win_s;
      rr_found_s = rr_found_s | s_axis_tvalid[cand];
    end
  end

  // Next-state, grant and arbitration-state computation
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    consec_d = consec_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (|s_axis_tvalid)) begin
          state_d = ST_ACTIVE;
          grant_d = '0;
          if (s_axis_tvalid[0] && ((consec_q < CONSEC_MAX) || !any_other_s)) begin
            gidx_d     = '0;
            grant_d[0] = 1'b1;
            consec_d   = (consec_q < CONSEC_MAX) ? consec_q + CNT_W'(1) : consec_q;
          end else begin
            gidx_d            = rr_win_s;
            grant_d[rr_win_s] = 1'b1;
            rr_ptr_d          = (rr_win_s == LAST_IDX) ? FIRST_RR : rr_win_s + IDX_W'(1);
            consec_d          = '0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        // Lock is released only by the tlast handshake; one idle bubble follows
        if (hs_last_s) begin
          state_d = ST_IDLE;
          grant_d = '0;
          count_d = count_q + 16'd1;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Combinational pass-through from the granted port
  always_comb begin
    m_axis_tdata  = active_s ? tdata_arr[gidx_q] : '0;
    m_axis_tkeep  = active_s ? tkeep_arr[gidx_q] : '0;
    m_axis_tuser  = active_s ? tuser_arr[gidx_q] : '0;
    m_axis_tvalid = active_s & s_axis_tvalid[gidx_q];
    m_axis_tlast  = active_s & s_axis_tlast[gidx_q];
    s_axis_tready = active_s ? (grant_q & {NUM_REQ{m_axis_tready}}) : '0;
  end

  // State and arbitration registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= FIRST_RR;
      consec_q <= '0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      consec_q <= consec_d;
      count_q  <= count_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = active_s;
  assign dllp_count_o = count_q;

endmodule

// File: tb/tb_pcie_dllp_tx_arbiter.sv
// Self-checking bench for pcie_dllp_tx_arbiter: a cycle vector table plus
// queued-source scenarios checked against an expected-beat scoreboard.
module tb_pcie_dllp_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int UW = 3;

  logic             clk = 1'b0;
  logic             rst_i;
  logic [NR*DW-1:0] s_tdata;
  logic [NR*KW-1:0] s_tkeep;
  logic [NR-1:0]    s_tvalid;
  logic [NR-1:0]    s_tlast;
  logic [NR*UW-1:0] s_tuser;
  logic [NR-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tvalid;
  logic             m_tlast;
  logic [UW-1:0]    m_tuser;
  logic             m_tready;
  logic             enable;
  logic [NR-1:0]    grant_o;
  logic             busy_o;
  logic [15:0]      count_o;

  always #5 clk = ~clk;

  pcie_dllp_tx_arbiter #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .NUM_REQ(NR), .P0_MAX_CONSEC(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .enable_i(enable), .grant_o(grant_o), .busy_o(busy_o), .dllp_count_o(count_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  vld;
    logic [1:0]  dport;
    logic [31:0] dat;
    logic        lst;
    logic        mrdy;
    logic        en;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_mvalid;
    logic        e_mlast;
    logic [3:0]  e_sready;
    logic [31:0] e_mdata;
    logic [15:0] e_count;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic [2:0]  user;
    logic [3:0]  grant;
  } beat_t;

  vec_t        vecs [17];
  beat_t       exp_q [$];
  logic [31:0] pq [NR][$];
  int          beat_idx [NR];
  bit          q_mode = 1'b0;
  bit          sb_on  = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_of(input logic [31:0] body);
    return body[15:0] ^ 16'h5A5A;
  endfunction

  task automatic add_pkt(input int p, input logic [31:0] body);
    pq[p].push_back(body);
  endtask

  task automatic exp_pkt(input int p, input logic [31:0] body);
    logic [3:0] g;
    beat_t b;
    g = 4'b0001 << p;
    b = '{body, 4'hF, 1'b0, 3'(p), g};
    exp_q.push_back(b);
    b = '{{16'h0000, crc_of(body)}, 4'h3, 1'b1, 3'(p), g};
    exp_q.push_back(b);
  endtask

  task automatic drive_q();
    for (int p = 0; p < NR; p++) begin
      if (pq[p].size() > 0) begin
        s_tvalid[p]          = 1'b1;
        s_tlast[p]           = (beat_idx[p] == 1);
        s_tdata[p*DW +: DW]  = (beat_idx[p] == 1) ? {16'h0000, crc_of(pq[p][0])} : pq[p][0];
        s_tkeep[p*KW +: KW]  = (beat_idx[p] == 1) ? 4'h3 : 4'hF;
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tlast[p]           = 1'b0;
        s_tdata[p*DW +: DW]  = 32'h0;
        s_tkeep[p*KW +: KW]  = 4'h0;
      end
      s_tuser[p*UW +: UW] = 3'(p);
    end
  endtask

  task automatic drive_row(input vec_t v);
    for (int p = 0; p < NR; p++) begin
      s_tvalid[p]         = v.vld[p];
      s_tlast[p]          = v.lst;
      s_tdata[p*DW +: DW] = (p == int'(v.dport)) ? v.dat : ~v.dat;
      s_tkeep[p*KW +: KW] = v.lst ? 4'h3 : 4'hF;
      s_tuser[p*UW +: UW] = 3'(p);
    end
    m_tready = v.mrdy;
    enable   = v.en;
  endtask

  // One clock: sample/score at negedge, advance sources, drive just after posedge
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (sb_on && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got %h grant %b", m_tdata, grant_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 64'({m_tdata, m_tkeep, m_tlast, m_tuser, grant_o}), 64'(e));
      end
    end
    if (q_mode) begin
      for (int p = 0; p < NR; p++) begin
        if (s_tvalid[p] && s_tready[p]) begin
          if (beat_idx[p] == 0) begin
            beat_idx[p] = 1;
          end else begin
            beat_idx[p] = 0;
            void'(pq[p].pop_front());
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (q_mode) drive_q();
  endtask

  task automatic wait_left(input int left, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > left && n < budget) begin
      step();
      n++;
    end
    chk("sb_pending", 64'(exp_q.size()), 64'(left));
  endtask

  task automatic clear_src();
    for (int p = 0; p < NR; p++) begin
      pq[p].delete();
      beat_idx[p] = 0;
    end
    drive_q();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    exp_q.delete();
    clear_src();
    m_tready = 1'b1;
    enable   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // vld dport dat lst mrdy en | grant busy mvalid mlast sready mdata count
    vecs[0]  = '{4'b0100, 2'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd0};
    vecs[1]  = '{4'b0100, 2'd2, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 32'hDEADBEEF, 16'd0};
    vecs[2]  = '{4'b0100, 2'd2, 32'h00001234, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 32'h00001234, 16'd0};
    vecs[3]  = '{4'b0100, 2'd2, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd1};
    vecs[4]  = '{4'b0100, 2'd2, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 32'hCAFEF00D, 16'd1};
    vecs[5]  = '{4'b0100, 2'd2, 32'h00005678, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 32'h00005678, 16'd1};
    vecs[6]  = '{4'b0100, 2'd2, 32'h00005678, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 32'h00005678, 16'd1};
    vecs[7]  = '{4'b0000, 2'd2, 32'h0,        1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd2};
    vecs[8]  = '{4'b1000, 2'd3, 32'h11112222, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd2};
    vecs[9]  = '{4'b1000, 2'd3, 32'h11112222, 1'b0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h11112222, 16'd2};
    vecs[10] = '{4'b1111, 2'd3, 32'h00003333, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 32'h00003333, 16'd2};
    vecs[11] = '{4'b1111, 2'd3, 32'h44445555, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd3};
    vecs[12] = '{4'b1111, 2'd3, 32'h44445555, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd3};
    vecs[13] = '{4'b1111, 2'd3, 32'h44445555, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd3};
    vecs[14] = '{4'b1111, 2'd3, 32'h44445555, 1'b0, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 4'b0001, 32'hBBBBAAAA, 16'd3};
    vecs[15] = '{4'b0001, 2'd0, 32'h0000ABCD, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 32'h0000ABCD, 16'd3};
    vecs[16] = '{4'b0000, 2'd0, 32'h0,        1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        16'd4};

    rst_i = 1'b1;
    m_tready = 1'b1;
    enable = 1'b1;
    for (int p = 0; p < NR; p++) beat_idx[p] = 0;
    drive_q();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({grant_o, busy_o, m_tvalid, s_tready, count_o}), 64'(0));
    @(posedge clk);
    #1;
    rst_i = 1'b0;

    // Cycle-accurate table: single source timing, backpressure on CRC, enable_i gating
    for (int i = 0; i < 17; i++) begin
      drive_row(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          64'({grant_o, busy_o, m_tvalid, s_tready, count_o}),
          64'({vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_mvalid, vecs[i].e_sready, vecs[i].e_count}));
      if (vecs[i].e_mvalid) begin
        chk($sformatf("vec%0d_data", i),
            64'({m_tdata, m_tkeep, m_tlast}),
            64'({vecs[i].e_mdata, (vecs[i].lst ? 4'h3 : 4'hF), vecs[i].e_mlast}));
      end
      @(posedge clk);
      #1;
    end

    // Round-robin over ports 1..3
    do_reset();
    q_mode = 1'b1;
    sb_on  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 1; p < NR; p++) begin
        add_pkt(p, 32'hA000_0000 | (r << 8) | p);
        exp_pkt(p, 32'hA000_0000 | (r << 8) | p);
      end
    end
    drive_q();
    wait_left(0, 60);

    // Starvation bound: 0,0,0,0,1,0,0,0,0,1
    do_reset();
    for (int i = 0; i < 8; i++) add_pkt(0, 32'hB000_0000 | i);
    add_pkt(1, 32'hB100_0000);
    add_pkt(1, 32'hB100_0001);
    for (int i = 0; i < 4; i++) exp_pkt(0, 32'hB000_0000 | i);
    exp_pkt(1, 32'hB100_0000);
    for (int i = 4; i < 8; i++) exp_pkt(0, 32'hB000_0000 | i);
    exp_pkt(1, 32'hB100_0001);
    drive_q();
    wait_left(0, 100);

    // Backpressure and lock: port 1 holds grant while port 0 waits
    do_reset();
    add_pkt(1, 32'hC100_0001);
    exp_pkt(1, 32'hC100_0001);
    drive_q();
    wait_left(1, 10);
    add_pkt(0, 32'hC000_0000);
    exp_pkt(0, 32'hC000_0000);
    m_tready = 1'b0;
    drive_q();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_lock", 64'({grant_o, s_tready[0], m_tvalid, m_tlast}), 64'({4'b0010, 1'b0, 1'b1, 1'b1}));
      @(posedge clk);
      #1;
    end
    m_tready = 1'b1;
    wait_left(0, 20);

    // Reset mid-packet: partial packet dropped, rr_ptr back to 1
    sb_on = 1'b0;
    add_pkt(1, 32'h5555AAAA);
    drive_q();
    step();
    step();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_pkt", 64'({grant_o, busy_o, m_tvalid, s_tready, count_o}), 64'(0));
    clear_src();
    @(posedge clk);
    #1;
    sb_on = 1'b1;
    for (int p = 1; p < NR; p++) begin
      add_pkt(p, 32'hD000_0000 | p);
      exp_pkt(p, 32'hD000_0000 | p);
    end
    drive_q();
    wait_left(0, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_dllp_tx_arbiter.md
# pcie_dllp_tx_arbiter

Packet-locked arbiter that shares the single DLLP transmit AXI-stream between DLLP sources: ACK/NAK generator, flow-control init/UpdateFC generators and PM DLLP source. Each DLLP arrives as two beats: a 4-byte body with tkeep all ones, then a CRC beat with tkeep 0x3 and tlast. The arbiter grants one source at a time and never interleaves beats of different DLLPs. ACK/NAK on port 0 has priority, bounded by an anti-starvation limit; the other ports are served round-robin. It sits between the DLLP generators and the physical-layer framing input.

## Interface
- DATA_WIDTH, 32, beat width in bits
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- USER_WIDTH, 3, tuser width, passed through
- NUM_REQ, 4, number of source ports (≥2); port 0 is the priority (ACK/NAK) port
- P0_MAX_CONSEC, 4, maximum consecutive port-0 grants while another port is waiting (≥1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- s_axis_tdata  in  NUM_REQ*DATA_WIDTH  per-port data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_REQ*KEEP_WIDTH  per-port keep
- s_axis_tvalid  in  NUM_REQ  per-port valid
- s_axis_tlast  in  NUM_REQ  per-port last
- s_axis_tuser  in  NUM_REQ*USER_WIDTH  per-port user
- s_axis_tready  out  NUM_REQ  per-port ready
- m_axis_tdata  out  DATA_WIDTH  arbitrated data
- m_axis_tkeep  out  KEEP_WIDTH  arbitrated keep
- m_axis_tvalid  out  1  arbitrated valid
- m_axis_tlast  out  1  arbitrated last
- m_axis_tuser  out  USER_WIDTH  arbitrated user
- m_axis_tready  in  1  downstream ready
- enable_i  in  1  allows new grants; when low, the current packet completes and no new grant is issued
- grant_o  out  NUM_REQ  registered one-hot grant; all zero when idle
- busy_o  out  1  high while a packet is locked (ST_ACTIVE)
- dllp_count_o  out  16  count of completed DLLPs (tlast handshakes); wraps at 0xFFFF→0

## Operation
State machine with two states.
- ST_IDLE
  - grant_o = 0.
  - All s_axis_tready and m_axis_tvalid are 0.
  - If enable_i=1 and any s_axis_tvalid is high, choose a winner, register it into grant_o, and go to ST_ACTIVE.
- ST_ACTIVE (granted port g)
  - Combinational pass-through: m_axis_tdata, tkeep, tvalid, tlast and tuser equal port g's inputs.
  - s_axis_tready[g] = m_axis_tready; all other s_axis_tready = 0.
  - On a handshake with m_axis_tlast=1: go to ST_IDLE, increment dllp_count_o, update the arbitration state.
- Winner selection in ST_IDLE:
  - Port 0 valid and (consec_cnt < P0_MAX_CONSEC, or no other port valid) → port 0; consec_cnt++ (saturating at P0_MAX_CONSEC).
  - Otherwise, round-robin over ports 1..NUM_REQ-1: the first valid port at or after rr_ptr, wrapping from NUM_REQ-1 to 1.
    - On that grant, rr_ptr ← winner+1, wrapping to 1.
    - consec_cnt ← 0.
  - A port-0 grant made while no other port is valid also leaves consec_cnt unchanged once it is saturated.
- Lock rules:
  - The grant is held until the tlast handshake, regardless of enable_i or other requests.
  - If port g drops tvalid mid-packet, m_axis_tvalid drops too and the lock is held.
- Reset values:
  - State ST_IDLE; grant_o 0; busy_o 0; dllp_count_o 0.
  - m_axis_tvalid 0; all s_axis_tready 0.
  - rr_ptr 1; consec_cnt 0.

## Timing
- Arbitration latency: the first cycle a valid is seen in ST_IDLE issues the grant; the first beat is forwarded the next cycle.
- Each DLLP occupies its beat cycles plus one ST_IDLE bubble cycle after tlast. A 2-beat DLLP with m_axis_tready held high takes 3 cycles; the next DLLP starts on cycle 4.
- The data path adds no register stage. m_axis outputs depend combinationally on the registered grant and the source inputs. m_axis_tready reaches s_axis_tready combinationally.
- dllp_count_o, grant_o and busy_o update on the clock edge after the qualifying event.
- enable_i is sampled only in ST_IDLE. Deasserting it in the tlast cycle still completes that packet; no new grant follows.
- rst_i asserted mid-packet: the next cycle is ST_IDLE with all outputs at reset values. The partial packet is abandoned and not counted.
- Simultaneous tlast handshake and new requests: no same-cycle regrant; new requests are evaluated in the following ST_IDLE cycle.

## Test plan
- Single source: port 2 sends body 0xDEADBEEF then CRC 0x1234 (tkeep 0x3, tlast), m_axis_tready=1 → grant_o=0b0100 for 2 cycles, beats appear unchanged, dllp_count_o=1, the next grant is no earlier than cycle 4.
- Round-robin: ports 1, 2 and 3 each have a DLLP continuously queued, port 0 idle → grant order 1,2,3,1,2,3; each packet is whole and never interleaved.
- Starvation bound: ports 0 and 1 continuously valid, P0_MAX_CONSEC=4 → grant order 0,0,0,0,1,0,0,0,0,1.
- Backpressure and lock: m_axis_tready low for 5 cycles after the body beat of port 1 while port 0 asserts valid → port 1 stays granted, port 0 tready stays 0; port 0 is granted only after port 1's tlast handshake.
- enable_i: deassert enable_i during port 3's body beat → packet completes, dllp_count_o increments, grant_o stays 0 while enable_i=0 even with all ports valid; grants resume one cycle after re-enable.
- Reset mid-packet: assert rst_i after port 1's body beat → the next cycle shows grant_o=0, m_axis_tvalid=0, dllp_count_o=0, rr_ptr back to 1.
